serial_cmp_arbiter: RTL and testbench

SERIAL_CMP_ARBITER -- requirements
Module: serial_cmp_arbiter

---
 rtl/serial_cmp_pkg.sv | 6 +
 rtl/serial_cmp_msb_core.sv | 23 ++
 rtl/serial_cmp_arbiter.sv | 83 ++++++++
 tb/tb_serial_cmp_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared state encodings and requester count for the serial comparator arbiter.
package serial_cmp_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} arb_state_t;
  typedef enum logic [1:0] {EQ, LT, GT} cmp_state_t;
endpackage

// File: rtl/serial_cmp_msb_core.sv
// serial_cmp_msb_core: MSB-first bit-serial unsigned comparator; latches on the first differing bit.
module serial_cmp_msb_core
  import serial_cmp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic lt,
  output logic eq,
  output logic gt
);
  cmp_state_t r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= EQ;
    else if (clr) r_state <= EQ;
    else if (en && r_state == EQ && a != b) r_state <= b ? LT : GT;
  assign lt = r_state == LT;
  assign eq = r_state == EQ;
  assign gt = r_state == GT;
endmodule

// File: rtl/serial_cmp_arbiter.sv
// serial_cmp_arbiter: two-requester round-robin front end for a bit-serial comparator.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the operand bits first differ.
module serial_cmp_arbiter
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            res_id,
  output logic                            res_less,
  output logic                            res_eq,
  output logic                            res_greater,
  output logic                            busy
);
  localparam int CW = $clog2(WIDTH);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif
  arb_state_t r_state, w_next;
  logic r_ptr, r_id;
  logic [WIDTH-1:0] r_a, r_b;
  logic [CW-1:0] r_cnt;
  logic w_accept, w_gnt, w_shift, w_done, w_lt, w_eq, w_gt;
  always_comb begin
    w_accept = r_state == IDLE && |req_valid;
    w_gnt = &req_valid ? r_ptr : req_valid[1];
    w_shift = r_state == SHIFT;
    w_done = r_cnt == '0 || (EARLY_EXIT && r_a[WIDTH-1] != r_b[WIDTH-1]);
    w_next = r_state == IDLE ? (w_accept ? SHIFT : IDLE)
           : r_state == SHIFT ? (w_done ? DONE : SHIFT)
           : (res_ready ? IDLE : DONE);
    req_ready = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    busy = r_state != IDLE;
    res_valid = r_state == DONE;
    res_id = r_id;
    res_less = res_valid & w_lt;
    res_eq = res_valid & w_eq;
    res_greater = res_valid & w_gt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= 1'b0;
      r_id <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a <= req_a[w_gnt];
        r_b <= req_b[w_gnt];
        r_id <= w_gnt;
        r_cnt <= CW'(WIDTH - 1);
      end else if (w_shift) begin
        r_a <= r_a << 1;
        r_b <= r_b << 1;
        r_cnt <= r_cnt - CW'(1);
      end
      // hand priority to the other requester once a result is consumed
      if (r_state == DONE && res_ready) r_ptr <= ~r_id;
    end
  serial_cmp_msb_core u_core (
    .clk(clk),
    .rst_n(rst_n),
    .clr(w_accept),
    .en(w_shift),
    .a(r_a[WIDTH-1]),
    .b(r_b[WIDTH-1]),
    .lt(w_lt),
    .eq(w_eq),
    .gt(w_gt)
  );
endmodule

// File: tb/tb_serial_cmp_arbiter.sv
// tb_serial_cmp_arbiter: directed vector table, reset-abort sequence and randomized model checks.
module tb_serial_cmp_arbiter;
  localparam int W = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, res_ready = 1'b0;
  logic [1:0] req_valid = '0, req_ready;
  logic [1:0][W-1:0] req_a = '0, req_b = '0;
  logic res_valid, res_id, res_less, res_eq, res_greater, busy;
  int checks = 0, errors = 0;
  logic m_ptr = 1'b0;
  always #5 clk = ~clk;
  serial_cmp_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_less(res_less), .res_eq(res_eq), .res_greater(res_greater), .busy(busy)
  );
  typedef struct {
    logic [1:0] v;
    logic [W-1:0] a0, b0, a1, b1;
    logic id;
    logic [2:0] f;
    int lat_ne, lat_ee, stall;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [2:0] flags();
    return {res_less, res_eq, res_greater};
  endfunction
  function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b);
    return a < b ? 3'b100 : a == b ? 3'b010 : 3'b001;
  endfunction
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    if (!EE) return W + 1;
    for (int k = 0; k < W; k++) if (a[W-1-k] != b[W-1-k]) return k + 2;
    return W + 1;
  endfunction
  task automatic txn(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input logic eid,
                     input logic [2:0] ef, input int elat, input int stall);
    int n;
    req_valid = v; req_a = {a1, a0}; req_b = {b1, b0}; res_ready = 1'b0;
    #1;
    chk("grant", {30'd0, req_ready}, eid ? 2'b10 : 2'b01);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    req_valid = 2'b11; req_a = {8'($urandom), 8'($urandom)}; req_b = {8'($urandom), 8'($urandom)};
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!res_valid) begin
        chk("shift_ready", {30'd0, req_ready}, 0);
        chk("shift_busy", busy, 1);
        chk("shift_flags", flags(), 0);
      end
    end while (!res_valid && n < 64);
    chk("latency", n, elat);
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      chk("done_valid", res_valid, 1);
      chk("done_id", res_id, eid);
      chk("done_flags", flags(), ef);
      chk("done_ready", {30'd0, req_ready}, 0);
      chk("done_busy", busy, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", res_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_flags", flags(), 0);
    chk("post_grant_rr", {30'd0, req_ready}, eid ? 2'b01 : 2'b10);
    req_valid = 2'b00;
    m_ptr = ~eid;
  endtask
  initial begin
    tbl[0] = '{2'b11, 8'h01, 8'h80, 8'hFF, 8'h00, 1'b0, 3'b100, 9, 2, 0};
    tbl[1] = '{2'b11, 8'h01, 8'h80, 8'hFF, 8'h00, 1'b1, 3'b001, 9, 2, 0};
    tbl[2] = '{2'b11, 8'h01, 8'h80, 8'hFF, 8'h00, 1'b0, 3'b100, 9, 2, 0};
    tbl[3] = '{2'b01, 8'h64, 8'h62, 8'h00, 8'h00, 1'b0, 3'b001, 9, 7, 0};
    tbl[4] = '{2'b10, 8'h00, 8'h00, 8'h3C, 8'h3C, 1'b1, 3'b010, 9, 9, 0};
    tbl[5] = '{2'b01, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 3'b100, 9, 9, 5};
    tbl[6] = '{2'b10, 8'h00, 8'h00, 8'h80, 8'h7F, 1'b1, 3'b001, 9, 2, 1};
    tbl[7] = '{2'b01, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 3'b010, 9, 9, 0};
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_ready", {30'd0, req_ready}, 0);
    chk("rst_id", res_id, 0);
    chk("rst_flags", flags(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      txn(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].id, tbl[i].f,
          EE ? tbl[i].lat_ee : tbl[i].lat_ne, tbl[i].stall);
    // abort an equal-operand compare in the middle of its shift phase
    req_valid = 2'b10; req_a = '0; req_b = '0;
    #1;
    chk("abort_grant", {30'd0, req_ready}, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_flags", flags(), 0);
    chk("abort_id", res_id, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_result", res_valid, 0);
    end
    txn(2'b11, 8'h10, 8'h20, 8'h30, 8'h05, 1'b0, 3'b100, ref_lat(8'h10, 8'h20), 0);
    for (int i = 0; i < 40; i++) begin
      logic [1:0] v;
      logic [W-1:0] a0, b0, a1, b1, ea, eb;
      logic eid;
      v = 2'($urandom_range(1, 3));
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      if (i % 5 == 0) b0 = a0;
      if (i % 7 == 0) b1 = a1 ^ 8'h01;
      eid = v == 2'b11 ? m_ptr : v[1];
      ea = eid ? a1 : a0;
      eb = eid ? b1 : b0;
      txn(v, a0, b0, a1, b1, eid, ref_flags(ea, eb), ref_lat(ea, eb), $urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
